// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and byte-strobe merge for the 2R1W register file
package reg_file_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int MERGE_W = 256;
  localparam int MERGE_S = MERGE_W / 8;
  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_S-1:0] strb
  );
    logic [MERGE_W-1:0] res;
    for (int i = 0; i < MERGE_S; i++) res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: registered read port with write-first bypass
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STRB_W = DATA_W / 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [STRB_W-1:0] WrStrb,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid
);
  logic              hit;
  logic [DATA_W-1:0] rd_word;
  // masking the strobes on a miss makes the merge return the stored word untouched
  assign hit = WrEn && (WrAddr == RdAddr);
  assign rd_word = DATA_W'(strb_merge(MERGE_W'(mem[RdAddr]), MERGE_W'(WrData), MERGE_S'(hit ? WrStrb : '0)));
  always_ff @(posedge CLK) begin
    if (RST) begin
      RdData  <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) RdData <= rd_word;
    end
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two registered read ports, one byte-strobed write port
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [STRB_W-1:0] WrStrb,
  input  logic              RdEn0,
  input  logic [ADDR_W-1:0] RdAddr0,
  input  logic              RdEn1,
  input  logic [ADDR_W-1:0] RdAddr1,
  output logic [DATA_W-1:0] RdData0,
  output logic [DATA_W-1:0] RdData1,
  output logic              RdValid0,
  output logic              RdValid1
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge CLK) begin
    if (RST) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (WrEn) mem[WrAddr] <= DATA_W'(strb_merge(MERGE_W'(mem[WrAddr]), MERGE_W'(WrData), MERGE_S'(WrStrb)));
  end
  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRB_W(STRB_W), .DEPTH(DEPTH)) u_rd0 (
    .CLK(CLK), .RST(RST), .RdEn(RdEn0), .RdAddr(RdAddr0), .mem(mem),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
    .RdData(RdData0), .RdValid(RdValid0)
  );
  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRB_W(STRB_W), .DEPTH(DEPTH)) u_rd1 (
    .CLK(CLK), .RST(RST), .RdEn(RdEn1), .RdAddr(RdAddr1), .mem(mem),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
    .RdData(RdData1), .RdValid(RdValid1)
  );
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed plus random stimulus, scoreboard of expected read responses
module tb_reg_file_2r1w;
  logic        CLK = 1'b0, RST = 1'b1, WrEn = 1'b0, RdEn0 = 1'b0, RdEn1 = 1'b0;
  logic [2:0]  WrAddr = '0, RdAddr0 = '0, RdAddr1 = '0;
  logic [15:0] WrData = '0;
  logic [1:0]  WrStrb = '0;
  logic [15:0] RdData0, RdData1;
  logic        RdValid0, RdValid1;
  typedef struct {logic v; logic [15:0] d;} exp_t;
  exp_t        q0[$], q1[$];
  logic [15:0] model [8];
  logic [15:0] last0 = '0, last1 = '0;
  int          checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  reg_file_2r1w dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
    .RdEn0(RdEn0), .RdAddr0(RdAddr0), .RdEn1(RdEn1), .RdAddr1(RdAddr1),
    .RdData0(RdData0), .RdData1(RdData1), .RdValid0(RdValid0), .RdValid1(RdValid1)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rst, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [1:0] ws, input logic re0, input logic [2:0] ra0,
                     input logic re1, input logic [2:0] ra1);
    exp_t e0, e1;
    RST = rst; WrEn = we; WrAddr = wa; WrData = wd; WrStrb = ws;
    RdEn0 = re0; RdAddr0 = ra0; RdEn1 = re1; RdAddr1 = ra1;
    if (rst) begin
      foreach (model[i]) model[i] = '0;
      last0 = '0;
      last1 = '0;
      e0 = '{1'b0, 16'h0};
      e1 = '{1'b0, 16'h0};
    end else begin
      if (we) for (int b = 0; b < 2; b++) if (ws[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
      if (re0) last0 = model[ra0];
      if (re1) last1 = model[ra1];
      e0 = '{re0, last0};
      e1 = '{re1, last1};
    end
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge CLK);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk("rd0_valid", {15'b0, RdValid0}, {15'b0, e0.v});
    chk("rd0_data", RdData0, e0.d);
    chk("rd1_valid", {15'b0, RdValid1}, {15'b0, e1.v});
    chk("rd1_data", RdData1, e1.d);
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
    cyc(0, 1, a, d, s, 0, 0, 0, 0);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset wipes earlier contents
    wr(5, 16'hABCD, 2'b11);
    cyc(1, 0, 0, 0, 0, 1, 5, 1, 5);
    chk("rst_valid0", {15'b0, RdValid0}, 16'h0);
    chk("rst_data0", RdData0, 16'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i));
      chk("post_rst_rd0", RdData0, 16'h0);
      chk("post_rst_rd1", RdData1, 16'h0);
    end
    // basic write/read and hold
    wr(2, 16'h1234, 2'b11);
    cyc(0, 0, 0, 0, 0, 1, 2, 0, 0);
    chk("basic_rd0", RdData0, 16'h1234);
    chk("basic_vld0", {15'b0, RdValid0}, 16'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_rd0", RdData0, 16'h1234);
    chk("hold_vld0", {15'b0, RdValid0}, 16'h0);
    // byte strobes
    wr(3, 16'hAAAA, 2'b11);
    wr(3, 16'h5566, 2'b01);
    cyc(0, 0, 0, 0, 0, 1, 3, 0, 0);
    chk("strb_lo", RdData0, 16'hAA66);
    wr(3, 16'h7700, 2'b10);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3);
    chk("strb_hi", RdData1, 16'h7766);
    wr(3, 16'hFFFF, 2'b00);
    cyc(0, 0, 0, 0, 0, 1, 3, 0, 0);
    chk("strb_none", RdData0, 16'h7766);
    // write-first bypass
    wr(4, 16'h0F0F, 2'b11);
    wr(1, 16'h9999, 2'b11);
    cyc(0, 1, 4, 16'h1234, 2'b10, 1, 4, 1, 1);
    chk("bypass_rd0", RdData0, 16'h120F);
    chk("bypass_rd1", RdData1, 16'h9999);
    cyc(0, 1, 4, 16'hABCD, 2'b01, 1, 4, 1, 4);
    chk("bypass_both", RdData1, 16'h12CD);
    // dual-port stream
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i), 2'b11);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i));
      chk("stream_rd0", RdData0, 16'h1000 + 16'(i));
      chk("stream_rd1", RdData1, 16'h1000 + 16'(7 - i));
    end
    // reset mid-operation discards concurrent requests
    cyc(1, 1, 6, 16'hBEEF, 2'b11, 1, 6, 1, 6);
    chk("mid_rst_vld1", {15'b0, RdValid1}, 16'h0);
    cyc(0, 0, 0, 0, 0, 1, 6, 1, 7);
    chk("mid_rst_rd6", RdData0, 16'h0);
    for (int n = 0; n < 60; n++)
      cyc($urandom_range(0, 19) == 0, 1'($urandom), 3'($urandom), 16'($urandom), 2'($urandom),
          1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file with two independent registered read ports and one byte-strobed write port. It succeeds the single-port 8x16 register file. Reads and writes may now occur in the same cycle, with a defined write-to-read bypass. It sits beside the datapath as the general-purpose operand store.

## Interface
Parameters:
- `DATA_W`, 16: word width in bits; must be a multiple of 8.
- `ADDR_W`, 3: address width; depth is `DEPTH = 2**ADDR_W`.
- `STRB_W`, `DATA_W/8`: number of byte strobes (derived; do not override).

Ports:
- `CLK` in 1: sole clock; all logic on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `WrEn` in 1: write request.
- `WrAddr` in `ADDR_W`: write address.
- `WrData` in `DATA_W`: write data.
- `WrStrb` in `STRB_W`: byte-lane enables. Bit i covers `WrData[8i+7:8i]`.
- `RdEn0`, `RdEn1` in 1: read requests, port 0 and port 1.
- `RdAddr0`, `RdAddr1` in `ADDR_W`: read addresses.
- `RdData0`, `RdData1` out `DATA_W`: registered read data.
- `RdValid0`, `RdValid1` out 1: one-cycle pulse marking new `RdData` on that port.

## Operation
Reset:
- `RST`=1 at a rising edge clears all `DEPTH` entries to 0.
- It also clears `RdData0`/`RdData1` to 0 and `RdValid0`/`RdValid1` to 0.
- Requests sampled in that cycle are discarded. Reset overrides everything, including mid-stream.

Write:
- If `WrEn`=1, each byte lane i with `WrStrb[i]`=1 is updated at `WrAddr`.
- Lanes with strobe 0 keep their old value.
- `WrEn`=1 with `WrStrb`=0 changes nothing and is legal.

Read:
- If `RdEnN`=1, `RdDataN` captures entry `RdAddrN` and `RdValidN` is 1 in the next cycle.
- If `RdEnN`=0, `RdDataN` holds its previous value and `RdValidN` is 0.

Simultaneous events:
- Read and write in the same cycle are both performed. The old design dropped both.
- Read-during-write to the same address is write-first. The returned word is the merge of the old entry with the strobed bytes of `WrData`, bit-exact with what the array holds afterwards.
- Both read ports may target the same address, or the write address, in the same cycle. Each port behaves independently as above.
- Out-of-range addresses cannot occur (`DEPTH = 2**ADDR_W`), so there is no wrap logic.

## Timing
- Write latency: the entry is updated at the sampling edge. A read issued in the next cycle sees it. A read in the same cycle sees it via the bypass.
- Read latency: 1 cycle, from the request edge to `RdData`/`RdValid`.
- Back-to-back reads on every cycle are supported on both ports (throughput 1 per port per cycle).
- No handshake or backpressure. Requests are always accepted.
- First cycle after `RST` deasserts: all outputs are 0 and all entries read 0.

## Structure
- Shared package `reg_file_pkg` holds:
  - default `DATA_W`/`ADDR_W` constants;
  - a function `strb_merge(old, new, strb)` returning the byte-merged word, used by both the write path and the bypass.
- Sub-module `reg_file_rd_port` is instantiated twice. Inputs: `CLK`, `RST`, `RdEn`, `RdAddr`, the array contents, and the write bus for bypass. Outputs: `RdData`, `RdValid`.
- Storage array and write logic stay in the top module.

## Test plan
- Reset: write 0xABCD to addr 5, then pulse `RST` for 1 cycle. Reading all 8 addresses on both ports returns 0x0000. `RdData`=0 and `RdValid`=0 during and right after reset.
- Basic R/W: write 0x1234 to addr 2 with strobe 2'b11. Next cycle read port 0 addr 2 returns 0x1234 with `RdValid0`=1 for exactly 1 cycle. `RdData0` holds 0x1234 with `RdEn0`=0.
- Byte strobe: addr 3 holds 0xAAAA; write 0x5566 with strobe 2'b01. Reading addr 3 returns 0xAA66. Then write 0x77xx with strobe 2'b10; the read returns 0x7766.
- Bypass: addr 4 holds 0x0F0F. In the same cycle, write 0x1234 with strobe 2'b10, port 0 reads addr 4, and port 1 reads addr 1 (holding 0x9999). Response: `RdData0`=0x120F and `RdData1`=0x9999, both valid.
- Dual-port stream: fill addrs 0..7 with 0x1000+i. Issue a read every cycle for 8 cycles, port 0 ascending and port 1 descending. Each port returns the correct value one cycle after each request, with `RdValid` continuously high.
- Reset mid-operation: assert `RST` in the same cycle as a write to addr 6 and reads on both ports. Response: addr 6 reads 0 afterwards, and no `RdValid` pulse appears in the following cycle.
